// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
// Groups the fetch-stage control inputs, the instruction-ROM port and the
// F/D pipeline-register outputs into one bundle.
//   master : the surrounding core / hazard unit / ROM (drives controls and iInstrF)
//   slave  : fetch_stage itself (drives PC, F/D fields, flags and counter)
// Signals:
//   iStall, iFlushD, iPCSrcE, iPCTargetE  hazard / redirect controls
//   oPCF, iInstrF                         instruction ROM address / data
//   oInstrD, oPCD, oPCPlus4D, oValidD     F/D register contents
//   oMisalignedTarget, oFetchCount        status
// ---------------------------------------------------------------------------
interface fetch_stage_if;
    logic        iStall;
    logic        iFlushD;
    logic        iPCSrcE;
    logic [31:0] iPCTargetE;
    logic [31:0] oPCF;
    logic [31:0] iInstrF;
    logic [31:0] oInstrD;
    logic [31:0] oPCD;
    logic [31:0] oPCPlus4D;
    logic        oValidD;
    logic        oMisalignedTarget;
    logic [31:0] oFetchCount;

    modport master (
        output iStall, iFlushD, iPCSrcE, iPCTargetE, iInstrF,
        input  oPCF, oInstrD, oPCD, oPCPlus4D, oValidD, oMisalignedTarget, oFetchCount
    );

    modport slave (
        input  iStall, iFlushD, iPCSrcE, iPCTargetE, iInstrF,
        output oPCF, oInstrD, oPCD, oPCPlus4D, oValidD, oMisalignedTarget, oFetchCount
    );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Fetch-stage control and F/D pipeline register of the RV32I core. Owns the
// program counter, presents it to the combinational instruction ROM, and
// captures the returned word together with its PC and PC+4 for decode.
// Ports:
//   iClk  : clock, all state changes on the rising edge
//   iRst  : synchronous active-high reset
//   bus   : fetch_stage_if.slave (controls, ROM port, F/D outputs, status)
// Parameters:
//   RESET_PC  : word-aligned PC loaded on reset
//   NOP_INSTR : bubble word placed in F/D (addi x0,x0,0)
// Every output comes straight from a register.
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic          iClk,
    input  logic          iRst,
    fetch_stage_if.slave  bus
);

    logic [31:0] pc_q,       pc_d;
    logic [31:0] fd_instr_q, fd_instr_d;
    logic [31:0] fd_pc_q,    fd_pc_d;
    logic [31:0] fd_pc4_q,   fd_pc4_d;
    logic        fd_valid_q, fd_valid_d;
    logic        mis_q,      mis_d;
    logic [31:0] cnt_q,      cnt_d;
    logic [31:0] pc_plus4_s;

    assign pc_plus4_s = pc_q + 32'd4;

    // Next-state selection for the PC, the F/D register and the status flags.
    always_comb begin
        pc_d       = pc_q;
        fd_instr_d = fd_instr_q;
        fd_pc_d    = fd_pc_q;
        fd_pc4_d   = fd_pc4_q;
        fd_valid_d = fd_valid_q;
        cnt_d      = cnt_q;
        mis_d      = 1'b0;

        // A redirect wins over a stall; the low target bits are dropped.
        if (bus.iPCSrcE) begin
            pc_d  = {bus.iPCTargetE[31:2], 2'b00};
            mis_d = (bus.iPCTargetE[1:0] != 2'b00);
        end else if (!bus.iStall) begin
            pc_d = pc_plus4_s;
        end else begin
            pc_d = pc_q;
        end

        // The redirect also bubbles F/D so the wrong-path word never reaches decode.
        if (bus.iFlushD || bus.iPCSrcE) begin
            fd_instr_d = NOP_INSTR;
            fd_pc_d    = 32'h0000_0000;
            fd_pc4_d   = 32'h0000_0000;
            fd_valid_d = 1'b0;
        end else if (!bus.iStall) begin
            fd_instr_d = bus.iInstrF;
            fd_pc_d    = pc_q;
            fd_pc4_d   = pc_plus4_s;
            fd_valid_d = 1'b1;
            cnt_d      = cnt_q + 32'd1;
        end else begin
            fd_instr_d = fd_instr_q;
        end
    end

    // State registers with synchronous reset to the bubble / reset PC.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            pc_q       <= RESET_PC;
            fd_instr_q <= NOP_INSTR;
            fd_pc_q    <= 32'h0000_0000;
            fd_pc4_q   <= 32'h0000_0000;
            fd_valid_q <= 1'b0;
            mis_q      <= 1'b0;
            cnt_q      <= 32'h0000_0000;
        end else begin
            pc_q       <= pc_d;
            fd_instr_q <= fd_instr_d;
            fd_pc_q    <= fd_pc_d;
            fd_pc4_q   <= fd_pc4_d;
            fd_valid_q <= fd_valid_d;
            mis_q      <= mis_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.oPCF              = pc_q;
    assign bus.oInstrD           = fd_instr_q;
    assign bus.oPCD              = fd_pc_q;
    assign bus.oPCPlus4D         = fd_pc4_q;
    assign bus.oValidD           = fd_valid_q;
    assign bus.oMisalignedTarget = mis_q;
    assign bus.oFetchCount       = cnt_q;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Fetch-stage control and fetch/decode pipeline register for the pipelined RV32I core. Owns the program counter and drives it to the combinational instruction ROM. Captures the returned instruction word, with its PC and PC+4, into the F/D register for the decode stage. Handles hazard-unit stalls, decode flushes and branch/jump redirects from execute.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- NOP_INSTR, 32'h0000_0013, bubble word written into F/D on flush (addi x0,x0,0).

- iClk  in  1  clock; all state updates on rising edge.
- iRst  in  1  reset; synchronous, active-high.
- iStall  in  1  hazard-unit stall; holds PC and the F/D register.
- iFlushD  in  1  hazard-unit flush of the F/D register.
- iPCSrcE  in  1  taken branch/jump resolved in execute.
- iPCTargetE  in  32  redirect target from execute.
- oPCF  out  32  current fetch PC; drives the instruction ROM address.
- iInstrF  in  32  instruction word returned combinationally by the ROM for oPCF.
- oInstrD  out  32  F/D instruction.
- oPCD  out  32  F/D PC.
- oPCPlus4D  out  32  F/D PC+4.
- oValidD  out  1  F/D holds a real fetched instruction; 0 for a bubble.
- oMisalignedTarget  out  1  one-cycle flag: the last redirect target had nonzero bits [1:0].
- oFetchCount  out  32  count of instructions accepted into F/D.

## Operation
- All outputs are registered. There is no combinational path from any input to any output.
- PC register update, in priority order:
  1. iRst: PC <= RESET_PC.
  2. iPCSrcE: PC <= {iPCTargetE[31:2], 2'b00}.
  3. iStall: PC holds.
  4. Otherwise: PC <= PC + 4, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- F/D register update, in priority order:
  1. iRst: bubble.
  2. iFlushD or iPCSrcE: bubble.
  3. iStall: hold all F/D fields.
  4. Otherwise: advance, capturing iInstrF, oPCF, oPCF + 4 (mod 2^32) and valid = 1.
- Bubble = oInstrD = NOP_INSTR, oPCD = 0, oPCPlus4D = 0, oValidD = 0.
- Because iPCSrcE forces a bubble, the wrong-path instruction in fetch never reaches decode.
- A flush takes precedence over a simultaneous stall. A redirect takes precedence over a simultaneous stall.
- oFetchCount increments by 1 only on an advance edge; it wraps at 2^32.
- oMisalignedTarget:
  - Set for exactly one cycle on the edge that performs a redirect with iPCTargetE[1:0] != 0.
  - Cleared on every other edge.
  - The PC is still loaded with the aligned target in that case.

## Timing
- Reset values:
  - oPCF = RESET_PC
  - oInstrD = NOP_INSTR
  - oPCD = 0, oPCPlus4D = 0
  - oValidD = 0
  - oMisalignedTarget = 0
  - oFetchCount = 0
- Fetch latency: the word at address A appears on oInstrD one edge after oPCF = A, when that edge advances.
- First cycle after reset release: oPCF = RESET_PC and oValidD = 0. After the next advance edge: oValidD = 1 and oPCD = RESET_PC.
- Redirect penalty: the edge with iPCSrcE = 1 loads the target into oPCF and a bubble into F/D.
  - The target instruction reaches oInstrD one advance edge later.
  - Decode therefore sees exactly one fetch-side bubble per redirect.
- Stall with no flush or redirect: oPCF and all F/D outputs hold for every stalled cycle. No instruction is lost or duplicated.
- Reset asserted mid-stream overrides stall, flush and redirect on the same edge.
- iInstrF is sampled at the edge only. It must be stable for the address on oPCF by setup time.

## Test plan
- Reset then 4 free-running cycles, ROM words 0x11,0x22,0x33,0x44 at 0,4,8,12 -> oPCF sequence 0,4,8,12,16. oInstrD lags by one edge. oPCPlus4D = oPCD+4. oFetchCount = 4.
- Stall for 3 cycles while oPCF = 8 and oPCD = 4 -> all outputs frozen for 3 cycles. On release oInstrD = word@8. No count increment during the stall.
- Redirect iPCSrcE = 1, iPCTargetE = 0x40 at oPCF = 12 -> next cycle oPCF = 0x40 and oValidD = 0 with oInstrD = 0x00000013. One cycle later oPCD = 0x40.
- Redirect to 0x42 together with iStall = 1 -> oPCF = 0x40, F/D bubble, oMisalignedTarget = 1 for one cycle only.
- iFlushD = 1 with iStall = 1 -> PC holds, F/D bubble, count unchanged. RESET_PC = 32'hFFFF_FFFC run for 2 advances -> oPCF wraps to 0, then 4.
- Assert iRst during a redirect -> oPCF = RESET_PC, all other outputs at their reset values on the next cycle.
